// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the MIPS HI/LO pair.
// Iterates one bit per clock (shift-add multiply, restoring divide) on operand magnitudes.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        count;
  logic                 div_q;
  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     mag_a, mag_b, raw_a;
  logic [2*WIDTH-1:0]   acc, acc_step;

  logic                 idle, accept, last;
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     in_mag_a, in_mag_b;
  logic [WIDTH:0]       sum, shifted, diff;
  logic                 ge;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     hi_fix, lo_fix;

  assign idle   = (state == IDLE);
  assign accept = idle & start;
  assign last   = (count == CW'(WIDTH - 1));
  assign busy   = ~idle;
  assign stall  = busy | accept;

  assign sign_a   = op[0] & a[WIDTH-1];
  assign sign_b   = op[0] & b[WIDTH-1];
  assign in_mag_a = sign_a ? -a : a;
  assign in_mag_b = sign_b ? -b : b;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, mag_b};
    ge      = (shifted >= {1'b0, mag_b});
    if (div_q) begin
      if (ge) acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else    acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (dbz) begin
        hi_fix = raw_a;
        lo_fix = '1;
      end else begin
        lo_fix = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        hi_fix = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // mthi/mtlo only land in IDLE when no new operation is being accepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      div_q <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      raw_a <= '0;
      acc   <= '0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_q <= op[1];
            neg_a <= sign_a;
            neg_b <= sign_b;
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            raw_a <= a;
            count <= '0;
            dbz   <= op[1] & (b == '0);
            acc   <= op[1] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        FIX: begin
          hi   <= hi_fix;
          lo   <= lo_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit that owns the HI/LO register pair for the single-cycle MIPS datapath. It replaces the combinational multiply path in the ALU. The block accepts one operation per start handshake and iterates one bit per clock. It raises stall so the datapath holds the PC, then presents results on hi/lo for mfhi/mflo. It also services mthi/mtlo writes while idle.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low: reset==0 at a rising edge resets the block
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
wr_hi  input  1  mthi strobe
wr_lo  input  1  mtlo strobe
wdata  input  WIDTH  data for mthi/mtlo
busy  output  1  operation in progress
done  output  1  one-cycle pulse when hi/lo hold a new result
stall  output  1  combinational: busy | (start & idle); datapath holds PC and suppresses regwrite
dbz  output  1  last division had b==0; sticky until next accepted start or reset
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; hi=lo=0; busy=done=dbz=0; iteration counter=0. Reset has priority over everything, including mid-operation; any partial result is discarded.
- States:
  - IDLE -> RUN on start.
  - RUN -> RUN for WIDTH iterations.
  - RUN -> FIX after the WIDTH-th iteration.
  - FIX -> IDLE unconditionally.
- Accept edge E0 (IDLE, start=1):
  - latch op and a sign flags;
  - latch |a| and |b|, using magnitudes for signed ops and raw values for unsigned;
  - counter=0, busy<=1, dbz<=(op[1] & b==0).
- RUN: each edge performs one iteration, counter++.
  - Multiply: shift-add, one multiplier bit per edge.
  - Divide: restoring, one quotient bit per edge.
- Leaving RUN: the edge with counter==WIDTH-1 moves to FIX.
- FIX edge (E0+WIDTH+1):
  - apply sign correction and write hi/lo;
  - done<=1, busy<=0, state=IDLE.
- Timing: busy is high in cycles E0+1 .. E0+WIDTH+1. done is high only in the cycle after E0+WIDTH+1. Total latency is WIDTH+1 edges, independent of operand values.
- hi/lo are unchanged during RUN; they still show the previous result until the FIX edge.
- Sign rules:
  - MULT: 2*WIDTH-bit product negated if a and b signs differ; {hi,lo}=product.
  - DIV: quotient negated if signs differ, written to lo; remainder takes the sign of a, written to hi.
  - Unsigned ops: no correction.
- Division by zero (b==0, either div op): runs full latency; result lo=all ones, hi=a (raw operand); no sign correction; dbz=1.
- DIV of most-negative by -1: lo=0x80000000, hi=0, with no flag (magnitude arithmetic wraps naturally).
- start while busy (RUN/FIX): ignored; no queueing. stall stays high because busy=1.
- start in IDLE together with done high: accepted normally, giving back-to-back operations.
- wr_hi/wr_lo:
  - take effect only in IDLE with start=0; hi<=wdata / lo<=wdata at that edge.
  - Both strobes may be set together, in which case both registers take wdata.
  - Ignored while busy or when start=1 in the same cycle (start wins).
  - Do not affect done or dbz.
- done is never asserted by an mthi/mtlo write.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start one cycle -> busy for 33 cycles, stall high throughout, done pulse once; hi=0xFFFFFFFE lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14 hi=2; DIV a=0x80000000 b=-1 -> lo=0x80000000 hi=0.
- DIVU a=100 b=0 -> after 33 cycles dbz=1, lo=0xFFFFFFFF, hi=100; next accepted MULTU clears dbz at its accept edge.
- Start DIVU, pulse start again with new operands at cycle 5 -> ignored, first result delivered unchanged; assert reset==0 at cycle 10 of a new op -> next cycle busy=0 done=0 hi=lo=0; an op started afterwards completes with correct result.
- Idle wr_hi wdata=0x1234 -> hi=0x1234, done stays 0; wr_lo during busy -> lo unchanged; wr_lo and start same idle cycle -> operation accepted, lo not written.
